accumulate_load_sequencer: RTL and testbench
============================================

Name: accumulate_load_sequencer

Overview:
- Upstream feeder for the accumulate-reduce stage.
- Accepts a load command (array base, length, dest, pre-evaluated condition flag), pulls `length` u32 words from an input stream and writes them into consecutive u32 slots of the execution-environment register file.
- After the final word is written, issues one reduce request (arr, length, dest) to the accumulate-reduce stage over a valid/ready handshake.

Parameters:
ADDR_W, 8, width of u32 slot addresses, lengths and dest (address_u32_t width)
EV_LENGTH, 256, number of u32 slots in the execution environment (EV_Length_u32)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  load command valid
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_arr  in  ADDR_W  first destination slot
cmd_length  in  ADDR_W+1  number of words to load
cmd_dest  in  ADDR_W  reduce destination slot, passed through
cmd_cond  in  1  pre-evaluated conditional flag result (1 = execute)
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid&&in_ready
in_data  in  32  input u32 word
wr_en  out  1  register-file write strobe
wr_addr  out  ADDR_W  register-file slot
wr_data  out  32  register-file write data
red_valid  out  1  reduce request valid
red_ready  in  1  reduce stage accepts request
red_arr  out  ADDR_W  reduce array base
red_length  out  ADDR_W+1  reduce length
red_dest  out  ADDR_W  reduce destination
err  out  1  one-cycle pulse on a rejected command
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0 except cmd_ready=1; counters and latched command cleared.
- States: IDLE, LOAD, ISSUE.
- IDLE:
  - cmd_ready=1, in_ready=0.
  - On command handshake, latch arr/length/dest/cond and clear word counter k.
  - Reject the command if cmd_length==0 or cmd_arr+cmd_length>EV_LENGTH, computed at ADDR_W+2 bits with no wrap. A rejected command pulses err the next cycle and stays in IDLE; no words are consumed and no request is issued.
  - Otherwise go to LOAD.
- LOAD:
  - cmd_ready=0, in_ready=1, so one word per cycle at full rate.
  - On each input handshake: wr_en=1 in the next cycle with wr_addr=arr+k and wr_data=in_data. Outputs are registered, so latency is 1 cycle.
  - If the latched cond=0, words are still consumed to keep the stream aligned but wr_en stays 0.
  - When k reaches length-1 on a handshake: go to ISSUE if cond=1, else go to IDLE.
  - A cycle with in_valid=0 holds state and k and emits no write.
- ISSUE:
  - in_ready=0.
  - red_valid=1 with red_arr/red_length/red_dest from the latched command. These values stay stable while red_valid&&!red_ready.
  - ISSUE is entered the cycle after the last handshake, so the final wr_en is coincident with the first red_valid cycle. The reduce stage samples the register file no earlier than the cycle after accepting, so it sees the final word.
  - On red_ready, go to IDLE; cmd_ready is 1 in the following cycle.
- No command overlap: a new command is only accepted in IDLE.
- Back-to-back minimum: for length L with no stalls, cmd_ready returns L+2 cycles after command acceptance.
- Reset mid-operation: slots already written keep their values; no reduce request is issued; the input stream must be re-synchronised by the producer.
- wr_en is never asserted in IDLE or ISSUE except for the final-word write cycle described above.

Test Plan:
- Basic load: cmd arr=4,length=3,dest=10,cond=1; words 0x1,0x2,0xFFFFFFFF back-to-back -> writes (4,0x1),(5,0x2),(6,0xFFFFFFFF) on consecutive cycles; red_valid with arr=4,len=3,dest=10; cmd_ready again 5 cycles after accept with red_ready tied 1.
- Input bubbles and reduce backpressure: in_valid toggles 1,0,1,0,1 for length 3; red_ready held low 4 cycles -> exactly 3 writes at addresses 4..6; red_* fields stable throughout the stall; single request accepted.
- Condition false: cond=0, length=2 -> 2 words consumed, no wr_en, no red_valid, returns to IDLE.
- Boundary range: arr=254,length=2 (EV_LENGTH=256) -> accepted, writes slots 254 and 255. Then arr=255,length=2 -> err pulse, in_ready stays 0, no writes.
- Zero length: cmd_length=0 -> err pulse, state stays IDLE, no request issued.
- Reset mid-LOAD: assert reset_n=0 after 1 of 4 words -> outputs cleared immediately; after release no red_valid; a new command is accepted normally.

Source files
------------

// File: rtl/accumulate_load_sequencer.sv
// -----------------------------------------------------------------------------
// accumulate_load_sequencer
//
// Upstream feeder for the accumulate-reduce stage. A load command names a run
// of consecutive u32 slots in the execution-environment register file. The
// block pulls that many words from the input stream, writes them into the
// slots, and then hands one reduce request (arr, length, dest) to the
// accumulate-reduce stage. A command whose condition flag is false still
// drains its words so the stream stays aligned, but writes nothing and
// issues no request.
//
// Ports
//   clk, reset_n                     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              load command handshake (accepted in IDLE)
//   cmd_arr/cmd_length/cmd_dest      first slot, word count, reduce dest
//   cmd_cond                         pre-evaluated condition (1 = execute)
//   in_valid/in_ready/in_data        input u32 word stream
//   wr_en/wr_addr/wr_data            registered register-file write port
//   red_valid/red_ready              reduce request handshake
//   red_arr/red_length/red_dest      reduce request fields
//   err                              one-cycle pulse after a rejected command
//   busy                             high whenever not IDLE
// -----------------------------------------------------------------------------
module accumulate_load_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int EV_LENGTH = 256
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_arr,
  input  logic [ADDR_W:0]   cmd_length,
  input  logic [ADDR_W-1:0] cmd_dest,
  input  logic              cmd_cond,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              red_valid,
  input  logic              red_ready,
  output logic [ADDR_W-1:0] red_arr,
  output logic [ADDR_W:0]   red_length,
  output logic [ADDR_W-1:0] red_dest,
  output logic              err,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ISSUE = 2'd2
  } state_e;

  localparam logic [ADDR_W+1:0] EV_LEN_L = (ADDR_W+2)'(EV_LENGTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   arr_q, arr_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic                cond_q, cond_d;
  logic [ADDR_W:0]     k_q, k_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [31:0]         wr_data_q, wr_data_d;
  logic                err_q, err_d;

  // Range check is done two bits wider than a slot address so that
  // arr + length can reach EV_LENGTH (and beyond) without wrapping.
  logic [ADDR_W+1:0]   range_end;
  logic                cmd_bad;
  logic                last_word;

  assign range_end = {2'b00, cmd_arr} + {1'b0, cmd_length};
  assign cmd_bad   = (cmd_length == '0) || (range_end > EV_LEN_L);
  assign last_word = (k_q == len_q - (ADDR_W+1)'(1));

  // NOTE: every variable driven here gets a default first, so no path through
  // the case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    arr_d     = arr_q;
    len_d     = len_q;
    dest_d    = dest_q;
    cond_d    = cond_q;
    k_d       = k_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          arr_d  = cmd_arr;
          len_d  = cmd_length;
          dest_d = cmd_dest;
          cond_d = cmd_cond;
          k_d    = '0;
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: begin
        if (in_valid) begin
          // Words of a false-condition command are consumed but not written.
          wr_en_d   = cond_q;
          wr_addr_d = arr_q + k_q[ADDR_W-1:0];
          wr_data_d = in_data;
          if (last_word) begin
            state_d = cond_q ? S_ISSUE : S_IDLE;
          end else begin
            k_d = k_q + (ADDR_W+1)'(1);
          end
        end
      end

      S_ISSUE: begin
        if (red_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      arr_q     <= '0;
      len_q     <= '0;
      dest_q    <= '0;
      cond_q    <= 1'b0;
      k_q       <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      arr_q     <= arr_d;
      len_q     <= len_d;
      dest_q    <= dest_d;
      cond_q    <= cond_d;
      k_q       <= k_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      err_q     <= err_d;
    end
  end

  // Handshake outputs decode straight from the state register. The final
  // write of a load lands in the first ISSUE cycle; the reduce stage only
  // reads the register file after accepting, so it sees that word.
  assign cmd_ready  = (state_q == S_IDLE);
  assign in_ready   = (state_q == S_LOAD);
  assign busy       = (state_q != S_IDLE);
  assign red_valid  = (state_q == S_ISSUE);
  assign red_arr    = red_valid ? arr_q  : '0;
  assign red_length = red_valid ? len_q  : '0;
  assign red_dest   = red_valid ? dest_q : '0;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign err        = err_q;

endmodule

// File: tb/tb_accumulate_load_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for accumulate_load_sequencer. The driver issues commands and words;
// a reference model decides from the command alone which slot writes, error
// pulses and reduce requests must appear and queues them. A monitor on the
// falling clock edge pops and compares whatever the DUT presents.
// -----------------------------------------------------------------------------
module tb_accumulate_load_sequencer;

  localparam int ADDR_W    = 8;
  localparam int EV_LENGTH = 256;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_arr;
  logic [ADDR_W:0]   cmd_length;
  logic [ADDR_W-1:0] cmd_dest;
  logic              cmd_cond;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              red_valid;
  logic              red_ready;
  logic [ADDR_W-1:0] red_arr;
  logic [ADDR_W:0]   red_length;
  logic [ADDR_W-1:0] red_dest;
  logic              err;
  logic              busy;

  accumulate_load_sequencer #(.ADDR_W(ADDR_W), .EV_LENGTH(EV_LENGTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_arr    (cmd_arr),
    .cmd_length (cmd_length),
    .cmd_dest   (cmd_dest),
    .cmd_cond   (cmd_cond),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .red_valid  (red_valid),
    .red_ready  (red_ready),
    .red_arr    (red_arr),
    .red_length (red_length),
    .red_dest   (red_dest),
    .err        (err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int addr; logic [31:0] data; } wr_t;
  typedef struct { int arr; int len; int dest; } red_t;

  wr_t         wr_exp[$];
  red_t        red_exp[$];
  int          err_exp[$];
  logic [31:0] fixed_words[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  logic              stall_prev = 1'b0;
  logic [ADDR_W-1:0] prev_arr;
  logic [ADDR_W:0]   prev_len;
  logic [ADDR_W-1:0] prev_dest;

  always @(negedge clk) begin
    if (wr_en) begin
      if (wr_exp.size() == 0) check("unexpected_wr_en", 1, 0);
      else begin
        wr_t e;
        e = wr_exp.pop_front();
        check("wr_addr", 64'(wr_addr), 64'(e.addr));
        check("wr_data", 64'(wr_data), 64'(e.data));
      end
    end
    if (err) begin
      if (err_exp.size() == 0) check("unexpected_err", 1, 0);
      else void'(err_exp.pop_front());
    end
    if (stall_prev) begin
      check("red_valid_held", 64'(red_valid), 1);
      check("red_arr_stable", 64'(red_arr), 64'(prev_arr));
      check("red_len_stable", 64'(red_length), 64'(prev_len));
      check("red_dest_stable", 64'(red_dest), 64'(prev_dest));
    end
    if (red_valid) begin
      if (red_exp.size() == 0) check("unexpected_red_valid", 1, 0);
      else begin
        red_t r;
        r = red_exp[0];
        check("red_arr", 64'(red_arr), 64'(r.arr));
        check("red_length", 64'(red_length), 64'(r.len));
        check("red_dest", 64'(red_dest), 64'(r.dest));
        if (red_ready) void'(red_exp.pop_front());
      end
    end
    stall_prev = red_valid && !red_ready && reset_n;
    prev_arr   = red_arr;
    prev_len   = red_length;
    prev_dest  = red_dest;
  end

  // ---------------------------------------------------------- reference model
  function automatic bit cmd_ok(input int arr, input int len);
    return (len != 0) && (arr + len <= EV_LENGTH);
  endfunction

  task automatic wait_cmd_ready();
    int t = 0;
    while (!cmd_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) check("cmd_ready_timeout", 1, 0);
  endtask

  // One command end to end. abort_after >= 0 sends that many words and then
  // pulses reset instead of finishing the load.
  task automatic run_cmd(input int arr, input int len, input int dest, input bit cond,
                         input int bubble_pct, input int stall, input bit check_lat,
                         input int abort_after);
    logic [31:0] words[$];
    bit ok;
    int n_send;
    int e0;
    int t;

    ok = cmd_ok(arr, len);
    for (int i = 0; i < len; i++)
      words.push_back(fixed_words.size() > 0 ? fixed_words.pop_front() : $urandom);
    n_send = !ok ? 0 : (abort_after >= 0 ? abort_after : len);

    if (!ok) err_exp.push_back(1);
    else if (cond) begin
      for (int i = 0; i < n_send; i++) wr_exp.push_back('{arr + i, words[i]});
      if (abort_after < 0) red_exp.push_back('{arr, len, dest});
    end

    wait_cmd_ready();
    red_ready  = (stall == 0);
    cmd_valid  = 1'b1;
    cmd_arr    = ADDR_W'(arr);
    cmd_length = (ADDR_W+1)'(len);
    cmd_dest   = ADDR_W'(dest);
    cmd_cond   = cond;
    @(posedge clk); #1;
    e0 = cyc;
    cmd_valid = 1'b0;

    if (!ok) begin
      for (int i = 0; i < 3; i++) begin
        check("rej_in_ready", 64'(in_ready), 0);
        check("rej_busy", 64'(busy), 0);
        @(posedge clk); #1;
      end
      check("err_pulse_seen", 64'(err_exp.size()), 0);
      return;
    end

    for (int i = 0; i < n_send; i++) begin
      if (i > 0 && $urandom_range(99) < bubble_pct) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = words[i];
      t = 0;
      while (!in_ready && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
      if (t >= 50) check("in_ready_timeout", 1, 0);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end

    if (abort_after >= 0) begin
      @(negedge clk); #1;
      reset_n = 1'b0;
      #1;
      check("rst_wr_en", 64'(wr_en), 0);
      check("rst_red_valid", 64'(red_valid), 0);
      check("rst_busy", 64'(busy), 0);
      check("rst_in_ready", 64'(in_ready), 0);
      check("rst_cmd_ready", 64'(cmd_ready), 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
        check("post_rst_idle", 64'(busy), 0);
        @(posedge clk); #1;
      end
      check("post_rst_wr_drained", 64'(wr_exp.size()), 0);
      return;
    end

    if (!cond) begin
      check("cond0_back_idle", 64'(cmd_ready), 1);
      return;
    end

    repeat (stall) begin
      @(posedge clk); #1;
    end
    red_ready = 1'b1;
    wait_cmd_ready();
    // Accept cycle counts as cycle 0; cmd_ready must be back in cycle L+2.
    if (check_lat) check("cmd_ready_latency", 64'(cyc - e0 + 1), 64'(len + 2));
    check("red_issued", 64'(red_exp.size()), 0);
    red_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    reset_n    = 1'b0;
    cmd_valid  = 1'b0;
    cmd_arr    = '0;
    cmd_length = '0;
    cmd_dest   = '0;
    cmd_cond   = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    red_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cmd_ready", 64'(cmd_ready), 1);
    check("reset_in_ready", 64'(in_ready), 0);
    check("reset_wr_en", 64'(wr_en), 0);
    check("reset_red_valid", 64'(red_valid), 0);
    check("reset_err", 64'(err), 0);
    check("reset_busy", 64'(busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic load, no stalls, latency check.
    fixed_words = '{32'h1, 32'h2, 32'hFFFF_FFFF};
    run_cmd(4, 3, 10, 1'b1, 0, 0, 1'b1, -1);
    // Input bubbles between every word and reduce backpressure.
    run_cmd(4, 3, 10, 1'b1, 100, 4, 1'b0, -1);
    // Condition false: words drained, nothing written or issued.
    run_cmd(20, 2, 3, 1'b0, 0, 0, 1'b0, -1);
    // Boundary: last two slots accepted, one past the end rejected.
    run_cmd(254, 2, 7, 1'b1, 0, 0, 1'b1, -1);
    run_cmd(255, 2, 7, 1'b1, 0, 0, 1'b0, -1);
    // Zero length rejected.
    run_cmd(5, 0, 1, 1'b1, 0, 0, 1'b0, -1);
    // Reset after one of four words, then a normal command.
    run_cmd(40, 4, 9, 1'b1, 0, 0, 1'b0, 1);
    run_cmd(60, 5, 11, 1'b1, 0, 0, 1'b1, -1);

    // Randomized commands, some aimed at the top of the slot range.
    for (int n = 0; n < 30; n++) begin
      int arr;
      int len;
      len = $urandom_range(0, 12);
      arr = (n % 4 == 0) ? $urandom_range(240, 255) : $urandom_range(0, 255);
      run_cmd(arr, len, $urandom_range(0, 255), ($urandom_range(0, 3) != 0),
              30, $urandom_range(0, 3), 1'b0, -1);
    end

    repeat (5) @(posedge clk);
    #1;
    check("final_wr_queue_empty", 64'(wr_exp.size()), 0);
    check("final_red_queue_empty", 64'(red_exp.size()), 0);
    check("final_err_queue_empty", 64'(err_exp.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
